// File: rtl/mult_ctrl_pkg.sv
// Shared constants and the tag layout for the shared-multiplier controller.
// The tag travels beside each operation in the multiplier pipeline.
package mult_ctrl_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_LAT   = 2;
    localparam int MAX_NREQ  = 8;

    localparam int ID_W     = $clog2(DEF_NREQ);
    // The id field is sized for the largest legal NREQ, so one layout fits every build.
    localparam int TAG_ID_W = $clog2(MAX_NREQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr wins,
// with wrap-around. Nothing is granted while enable is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    int   j;
    logic found;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && enable && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                gnt_idx  = IDW'(j);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters and
// returns each product on a common response bus tagged with the requester id.
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_p,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]      rsp_p,
    output logic                    idle
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_idx;
    logic            hs;
    tag_t            tags [LAT+1];
    tag_t            last;
    logic            busy;

    // Handshake: requester i transfers its operands in the cycle where
    // req_valid[i] && req_ready[i]; operands must stay stable while valid && !ready.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .enable  (enable && !rst),
        .ptr     (ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (hs)
    );

    assign req_ready = grant;
    assign last      = tags[LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (hs) begin
            ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            mul_a <= req_a[gnt_idx*WIDTH +: WIDTH];
            mul_b <= req_b[gnt_idx*WIDTH +: WIDTH];
        end
    end

    // Stage 0 lines up with mul_a/mul_b; stage LAT lines up with mul_p.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LAT; s++) begin
                tags[s] <= '0;
            end
        end else begin
            tags[0].valid <= hs;
            tags[0].id    <= TAG_ID_W'(gnt_idx);
            for (int s = 1; s <= LAT; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else if (last.valid) begin
            rsp_valid <= NREQ'(1) << last.id;
            rsp_id    <= last.id[IDW-1:0];
            rsp_p     <= mul_p;
        end else begin
            rsp_valid <= '0;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s <= LAT; s++) begin
            busy = busy | tags[s].valid;
        end
    end

    assign idle = !busy && (rsp_valid == '0);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: a behavioural 2-cycle multiplier, a vector table
// of grant/idle expectations, and a scoreboard of expected responses.
module tb_mult_share_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  enable = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_p;
    logic [NREQ-1:0]       rsp_valid;
    logic [1:0]            rsp_id;
    logic [2*WIDTH-1:0]    rsp_p;
    logic                  idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mult_share_ctrl #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .idle      (idle)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier model, LAT = 2
    logic [63:0] p1 = '0;
    logic [63:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= longint'($signed(mul_a)) * longint'($signed(mul_b));
        p2 <= p1;
    end
    assign mul_p = p2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic [127:0] pk(input logic [31:0] x0, input logic [31:0] x1,
                                        input logic [31:0] x2, input logic [31:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    // Scoreboard: {id, product} with the cycle the response is due
    logic [65:0] exp_q[$];
    int          due_q[$];
    logic [1:0]  last_id = '0;
    logic [63:0] last_p  = '0;

    always @(negedge clk) begin
        logic [65:0] e;
        int          d;
        logic [3:0]  ev;
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            last_id = '0;
            last_p  = '0;
        end else if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
            end else begin
                e  = exp_q.pop_front();
                d  = due_q.pop_front();
                ev = 4'b0001 << e[65:64];
                chk("rsp_valid", {60'b0, rsp_valid}, {60'b0, ev});
                chk("rsp_id", {62'b0, rsp_id}, {62'b0, e[65:64]});
                chk("rsp_p", rsp_p, e[63:0]);
                chk("rsp_cycle", 64'(cyc), 64'(d));
                last_id = e[65:64];
                last_p  = e[63:0];
            end
        end else begin
            chk("rsp_p_hold", rsp_p, last_p);
            chk("rsp_id_hold", {62'b0, rsp_id}, {62'b0, last_id});
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rsp: got nothing expected id %0d due cycle %0d", exp_q[0][65:64], due_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    // Vector table
    typedef struct {
        logic         r;
        logic         en;
        logic [3:0]   v;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   rdy;
        logic         ci;
        logic         idl;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic r, input logic en, input logic [3:0] v,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic [3:0] rdy, input logic ci, input logic idl);
        vec_t e;
        e.r = r; e.en = en; e.v = v; e.a = a; e.b = b;
        e.rdy = rdy; e.ci = ci; e.idl = idl;
        tbl.push_back(e);
    endtask

    task automatic run_row(input vec_t e, input int n);
        rst       = e.r;
        enable    = e.en;
        req_valid = e.v;
        req_a     = e.a;
        req_b     = e.b;
        @(negedge clk);
        chk($sformatf("req_ready row%0d", n), {60'b0, req_ready}, {60'b0, e.rdy});
        if (e.ci) chk($sformatf("idle row%0d", n), {63'b0, idle}, {63'b0, e.idl});
        if (!e.r) begin
            for (int i = 0; i < NREQ; i++) begin
                if (e.rdy[i]) begin
                    exp_q.push_back({2'(i), prod(e.a[i*32 +: 32], e.b[i*32 +: 32])});
                    due_q.push_back(cyc + LAT + 2);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] z;
        logic [127:0] a3;
        logic [127:0] b3;
        logic [127:0] a6;
        logic [127:0] b6;
        z  = '0;
        a3 = pk(32'd125, 32'd7, -32'sd3, 32'd1000);
        b3 = pk(-32'sd18, 32'd9, -32'sd11, -32'sd1);
        a6 = pk(32'd11, -32'sd2, 32'd0, 32'd0);
        b6 = pk(32'd12, 32'd3, 32'd0, 32'd0);

        // Single issue from req0 and the idle window around it
        addv(0, 1, 4'b0001, pk(32'd20, 0, 0, 0), pk(32'd75, 0, 0, 0), 4'b0001, 1, 1);
        for (int i = 0; i < 4; i++) addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 0);
        addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 1);
        // Signed operands, pointer wraps from 3 to 1
        addv(0, 1, 4'b0100, pk(0, 0, -32'sd43, 0), pk(0, 0, -32'sd48, 0), 4'b0100, 1, 1);
        addv(0, 1, 4'b0010, pk(0, 32'd23, 0, 0), pk(0, -32'sd15, 0, 0), 4'b0010, 1, 0);
        for (int i = 0; i < 4; i++) addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 0);
        addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 1);
        // Reset with everyone requesting, then full rotation
        addv(1, 1, 4'b1111, a3, b3, 4'b0000, 0, 0);
        addv(0, 1, 4'b1111, a3, b3, 4'b0001, 1, 1);
        addv(0, 1, 4'b1111, a3, b3, 4'b0010, 1, 0);
        addv(0, 1, 4'b1111, a3, b3, 4'b0100, 1, 0);
        addv(0, 1, 4'b1111, a3, b3, 4'b1000, 1, 0);
        addv(0, 1, 4'b1111, a3, b3, 4'b0001, 1, 0);
        addv(0, 1, 4'b1111, a3, b3, 4'b0010, 1, 0);
        // Req3 streaming k*1
        for (int k = 1; k <= 8; k++)
            addv(0, 1, 4'b1000, pk(0, 0, 0, 32'(k)), pk(0, 0, 0, 32'd1), 4'b1000, 1, 0);
        for (int i = 0; i < 4; i++) addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 0);
        // Three issues, then reset discards them all
        addv(0, 1, 4'b0001, pk(32'd5, 0, 0, 0), pk(32'd6, 0, 0, 0), 4'b0001, 1, 1);
        addv(0, 1, 4'b0010, pk(0, -32'sd7, 0, 0), pk(0, 32'd8, 0, 0), 4'b0010, 1, 0);
        addv(0, 1, 4'b0100, pk(0, 0, 32'h7FFF_FFFF, 0), pk(0, 0, 32'd2, 0), 4'b0100, 1, 0);
        addv(1, 1, 4'b0000, z, z, 4'b0000, 0, 0);
        for (int i = 0; i < 4; i++) addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 1);
        // Pointer is back at 0: req1 wins over req3
        addv(0, 1, 4'b1010, pk(0, 32'd3, 0, 0), pk(0, 32'd4, 0, 0), 4'b0010, 1, 1);
        // 10*0 in flight while enable is low, then req0 before req1
        addv(0, 1, 4'b1000, pk(0, 0, 0, 32'd10), z, 4'b1000, 1, 0);
        for (int i = 0; i < 4; i++) addv(0, 0, 4'b0011, a6, b6, 4'b0000, 1, 0);
        addv(0, 1, 4'b0011, a6, b6, 4'b0001, 1, 1);
        addv(0, 1, 4'b0011, a6, b6, 4'b0010, 0, 0);
        for (int i = 0; i < 4; i++) addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 0);
        addv(0, 1, 4'b0000, z, z, 4'b0000, 1, 1);

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {60'b0, req_ready}, 64'd0);
        chk("reset mul_a", {32'b0, mul_a}, 64'd0);
        chk("reset mul_b", {32'b0, mul_b}, 64'd0);
        chk("reset rsp_valid", {60'b0, rsp_valid}, 64'd0);
        chk("reset rsp_id", {62'b0, rsp_id}, 64'd0);
        chk("reset rsp_p", rsp_p, 64'd0);
        chk("reset idle", {63'b0, idle}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < tbl.size(); n++) run_row(tbl[n], n);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
